fir_tdm_decim: RTL and testbench
================================

Name: fir_tdm_decim

Overview:
Multi-channel, decimating, time-multiplexed FIR filter with runtime-programmable coefficients. Uses one multiply-accumulate (MAC) unit, stepping through one tap per cycle. Generalises the fixed-tap pipelined FIR in three ways: per-channel sample histories, integer decimation, and valid/ready handshakes on both streams. Sits between a sample source (ADC or sweep generator) and downstream sample consumers.

Parameters:
DATA_W, 16, input sample width (signed, two's complement)
COEF_W, 16, coefficient width (signed)
TAPS, 32, number of taps per channel (>=2)
CHANNELS, 2, number of independent channels (>=1)
DECIM, 1, decimation factor (>=1); one output per DECIM accepted samples per channel
OUT_W, 32, output width
SHIFT, 0, arithmetic right shift applied to the accumulator before saturation
Derived: ACC_W = DATA_W + COEF_W + clog2(TAPS); CH_W = max(1, clog2(CHANNELS)); CA_W = max(1, clog2(TAPS))

Ports:
clk  input  1  clock, rising edge
rst_n  input  1  reset, asynchronous, active-high
s_data  input  DATA_W  input sample
s_chan  input  CH_W  channel index of s_data
s_valid  input  1  input sample valid
s_ready  output  1  block can accept a sample
coef_we  input  1  coefficient write strobe
coef_addr  input  CA_W  tap index k
coef_data  input  COEF_W  coefficient h[k], shared by all channels
m_data  output  OUT_W  filtered output sample
m_chan  output  CH_W  channel index of m_data
m_valid  output  1  output valid
m_ready  input  1  downstream accepts output

Behaviour:
- Reset (rst_n=1, asynchronous) clears:
  - FSM to IDLE; s_ready=0 while reset is asserted, 1 in the first cycle after release.
  - m_valid=0, m_data=0, m_chan=0.
  - All history registers, write pointers, decimation counters and coefficients to 0.
- Reset during MAC or OUT aborts the computation; no output is produced.
- Transfer rules: an input transfer occurs when s_valid & s_ready on a clock edge; an output transfer when m_valid & m_ready.
- s_ready = (state == IDLE).
- History: a CHANNELS x TAPS circular buffer with one write pointer per channel.
  - An accepted sample is written at that channel's pointer; the pointer then increments, wrapping from TAPS-1 to 0.
- s_chan >= CHANNELS: the sample is accepted and discarded; no state change.
- Decimation: each channel has a phase counter, 0..DECIM-1, incremented on every accepted sample.
  - When the counter was DECIM-1, it wraps to 0 and a computation starts (IDLE -> MAC).
  - Otherwise the FSM stays in IDLE, so s_ready stays high and back-to-back samples are accepted every cycle.
- FSM:
  - IDLE: waits for a computing sample. Edge E0 accepts the sample, latches the channel and clears the accumulator.
  - MAC: exactly TAPS cycles, edges E1..E_TAPS. On edge E(k+1): acc += h[k] * x[n-k] at full ACC_W precision, k=0..TAPS-1, where x[n] is the sample accepted at E0. Then -> OUT.
  - OUT: if the output register is empty, or is being read this cycle (m_ready=1), load m_data/m_chan, set m_valid=1 and go to IDLE. This happens on edge E_TAPS+1 when unblocked.
  - Otherwise OUT holds until the output register frees.
- Latency: m_valid rises TAPS+1 cycles after the accepting edge, assuming no backpressure.
- Throughput: with DECIM=1, one sample every TAPS+2 cycles.
- m_data stays stable while m_valid=1 & m_ready=0. m_valid drops after an output transfer unless a new result loads on the same edge.
- Output arithmetic: m_data = saturate_OUT_W(acc >>> SHIFT).
  - The shift truncates (floor).
  - Values above the OUT_W range clamp to 2^(OUT_W-1)-1; values below clamp to -2^(OUT_W-1).
- Coefficient writes: honoured only when state == IDLE; ignored (dropped) in MAC/OUT.
  - coef_we in the same IDLE cycle as an accepted computing sample: the write takes effect first, and that computation uses the new coefficient.
- History before the first TAPS samples of a channel reads as 0; the filter assumes zero initial state.

Test Plan:
Bench configuration unless stated: TAPS=8, CHANNELS=2, DECIM=1, OUT_W=32, SHIFT=0; coefficients h[k]=k+1.
1. Impulse: ch0 input 1000 followed by 7 zeros -> 8 ch0 outputs 1000, 2000, ..., 8000. The first m_valid occurs 9 cycles after the acceptance edge.
2. Channel isolation: interleave ch0 impulse 1000 with ch1 constant 100, 8 samples each -> ch0 outputs as in scenario 1. ch1 outputs 100, 300, 600, ..., 3600 (100 times the cumulative sum of h). m_chan matches each output.
3. Decimation (DECIM=4, all h=1): 16 consecutive ch0 samples of value 10 -> exactly 4 outputs with values 40, 80, 80, 80. s_ready stays high on non-computing samples.
4. Saturation (OUT_W=16, all h=32767): constant input 32767 -> m_data=32767; constant input -32768 -> m_data=-32768. With SHIFT=15 and a single tap of 16384 and input 16384 -> 8192.
5. Backpressure: hold m_ready=0 for 50 cycles after the first result -> m_data and m_chan stay constant, the FSM stalls in OUT with s_ready=0, and no sample is lost. After release, outputs match the golden model.
6. Reset and coefficient writes: assert rst_n mid-MAC -> no output, history is zeroed, and the next impulse reproduces scenario 1 only after reloading coefficients. A coef_we issued during MAC is ignored.

Source files
------------

// File: rtl/fir_tdm_decim.sv
// Multi-channel decimating FIR filter built around one shared MAC unit that handles one tap per cycle.
// Each channel keeps its own circular sample history. The coefficient set is common to all channels.
module fir_tdm_decim #(
    parameter int DATA_W   = 16,
    parameter int COEF_W   = 16,
    parameter int TAPS     = 32,
    parameter int CHANNELS = 2,
    parameter int DECIM    = 1,
    parameter int OUT_W    = 32,
    parameter int SHIFT    = 0,
    localparam int ACC_W   = DATA_W + COEF_W + $clog2(TAPS),
    localparam int CH_W    = (CHANNELS > 1) ? $clog2(CHANNELS) : 1,
    localparam int CA_W    = (TAPS > 1) ? $clog2(TAPS) : 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] s_data,
    input  logic [CH_W-1:0]   s_chan,
    input  logic              s_valid,
    output logic              s_ready,
    input  logic              coef_we,
    input  logic [CA_W-1:0]   coef_addr,
    input  logic [COEF_W-1:0] coef_data,
    output logic [OUT_W-1:0]  m_data,
    output logic [CH_W-1:0]   m_chan,
    output logic              m_valid,
    input  logic              m_ready
);

    localparam int PH_W   = (DECIM > 1) ? $clog2(DECIM) : 1;
    localparam int PROD_W = DATA_W + COEF_W;
    localparam int EXT_W  = (ACC_W > OUT_W) ? ACC_W : OUT_W;

    typedef enum logic [1:0] {IDLE = 2'd0, MAC = 2'd1, OUT = 2'd2} state_t;

    state_t                    r_state;
    logic signed [DATA_W-1:0]  r_hist [CHANNELS][TAPS];
    logic [CA_W-1:0]           r_wptr [CHANNELS];
    logic [PH_W-1:0]           r_phase [CHANNELS];
    logic signed [COEF_W-1:0]  r_coef [TAPS];
    logic [CH_W-1:0]           r_ch;
    logic [CA_W-1:0]           r_base;
    logic [CA_W-1:0]           r_k;
    logic signed [ACC_W-1:0]   r_acc;
    logic [OUT_W-1:0]          r_m_data;
    logic [CH_W-1:0]           r_m_chan;
    logic                      r_m_valid;

    logic                      w_chan_ok;
    logic [CA_W:0]             w_idx_ext;
    logic [CA_W-1:0]           w_rd_idx;
    logic signed [DATA_W-1:0]  w_x;
    logic signed [COEF_W-1:0]  w_h;
    logic signed [PROD_W-1:0]  w_prod;
    logic signed [ACC_W-1:0]   w_shifted;
    logic [OUT_W-1:0]          w_sat;

    // Clamp a shifted accumulator value into the signed OUT_W output range.
    function automatic logic [OUT_W-1:0] sat_out(input logic signed [ACC_W-1:0] v);
        logic signed [EXT_W-1:0] ve;
        logic signed [EXT_W-1:0] vmax;
        logic signed [EXT_W-1:0] vmin;
        ve   = EXT_W'(v);
        vmax = {{(EXT_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
        vmin = ~vmax;
        if (ve > vmax) begin
            sat_out = vmax[OUT_W-1:0];
        end else if (ve < vmin) begin
            sat_out = vmin[OUT_W-1:0];
        end else begin
            sat_out = ve[OUT_W-1:0];
        end
    endfunction

    assign s_ready   = (r_state == IDLE) & ~rst_n;
    assign w_chan_ok = (int'(s_chan) < CHANNELS);
    assign w_x       = r_hist[r_ch][w_rd_idx];
    assign w_h       = r_coef[r_k];
    assign w_prod    = w_x * w_h;
    assign w_shifted = r_acc >>> SHIFT;
    assign w_sat     = sat_out(w_shifted);
    assign m_data    = r_m_data;
    assign m_chan    = r_m_chan;
    assign m_valid   = r_m_valid;

    // History read address for tap k: x[n-k] sits k slots behind the newest sample, modulo TAPS.
    always_comb begin
        w_idx_ext = {1'b0, r_base} + (CA_W+1)'(TAPS) - {1'b0, r_k};
        w_rd_idx  = w_idx_ext[CA_W-1:0];
        if (w_idx_ext >= (CA_W+1)'(TAPS)) begin
            w_rd_idx = CA_W'(w_idx_ext - (CA_W+1)'(TAPS));
        end else begin
            w_rd_idx = w_idx_ext[CA_W-1:0];
        end
    end

    // Control FSM, sample history, coefficient store, MAC accumulator and output register.
    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            r_state   <= IDLE;
            r_ch      <= '0;
            r_base    <= '0;
            r_k       <= '0;
            r_acc     <= '0;
            r_m_data  <= '0;
            r_m_chan  <= '0;
            r_m_valid <= 1'b0;
            for (int c = 0; c < CHANNELS; c++) begin
                r_wptr[c]  <= '0;
                r_phase[c] <= '0;
                for (int t = 0; t < TAPS; t++) begin
                    r_hist[c][t] <= '0;
                end
            end
            for (int t = 0; t < TAPS; t++) begin
                r_coef[t] <= '0;
            end
        end else begin
            if (r_m_valid && m_ready) begin
                r_m_valid <= 1'b0;
            end
            case (r_state)
                IDLE: begin
                    if (coef_we && (int'(coef_addr) < TAPS)) begin
                        r_coef[coef_addr] <= coef_data;
                    end
                    // Samples addressed to a nonexistent channel are swallowed without touching state.
                    if (s_valid && w_chan_ok) begin
                        r_hist[s_chan][r_wptr[s_chan]] <= s_data;
                        if (r_wptr[s_chan] == CA_W'(TAPS - 1)) begin
                            r_wptr[s_chan] <= '0;
                        end else begin
                            r_wptr[s_chan] <= r_wptr[s_chan] + 1'b1;
                        end
                        if (r_phase[s_chan] == PH_W'(DECIM - 1)) begin
                            r_phase[s_chan] <= '0;
                            r_ch            <= s_chan;
                            r_base          <= r_wptr[s_chan];
                            r_acc           <= '0;
                            r_k             <= '0;
                            r_state         <= MAC;
                        end else begin
                            r_phase[s_chan] <= r_phase[s_chan] + 1'b1;
                        end
                    end
                end
                MAC: begin
                    r_acc <= r_acc + ACC_W'(w_prod);
                    if (r_k == CA_W'(TAPS - 1)) begin
                        r_state <= OUT;
                    end else begin
                        r_k <= r_k + 1'b1;
                    end
                end
                OUT: begin
                    if (!r_m_valid || m_ready) begin
                        r_m_data  <= w_sat;
                        r_m_chan  <= r_ch;
                        r_m_valid <= 1'b1;
                        r_state   <= IDLE;
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fir_tdm_decim.sv
// Directed bench for fir_tdm_decim: three instances cover the base, decimating and saturating/shifting configurations.
module tb_fir_tdm_decim;

    logic        clk;
    logic        rst_n;
    logic [15:0] tb_data;
    logic [1:0]  tb_chan;
    logic        tb_valid;
    int          tb_sel;
    logic        tb_cwe;
    logic [2:0]  tb_caddr;
    logic [15:0] tb_cdata;
    logic        tb_mready;

    logic        rdy_a, mv_a, rdy_d, mv_d, rdy_s, mv_s;
    logic [31:0] md_a, md_d;
    logic [15:0] md_s;
    logic [0:0]  mc_a, mc_s;
    logic [1:0]  mc_d;

    int n_vec = 0;
    int n_bad = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    fir_tdm_decim #(.DATA_W(16), .COEF_W(16), .TAPS(8), .CHANNELS(2), .DECIM(1),
                    .OUT_W(32), .SHIFT(0)) u_a (
        .clk(clk), .rst_n(rst_n),
        .s_data(tb_data), .s_chan(tb_chan[0:0]), .s_valid(tb_valid && tb_sel == 0), .s_ready(rdy_a),
        .coef_we(tb_cwe && tb_sel == 0), .coef_addr(tb_caddr), .coef_data(tb_cdata),
        .m_data(md_a), .m_chan(mc_a), .m_valid(mv_a), .m_ready(tb_mready));

    fir_tdm_decim #(.DATA_W(16), .COEF_W(16), .TAPS(8), .CHANNELS(3), .DECIM(4),
                    .OUT_W(32), .SHIFT(0)) u_d (
        .clk(clk), .rst_n(rst_n),
        .s_data(tb_data), .s_chan(tb_chan), .s_valid(tb_valid && tb_sel == 1), .s_ready(rdy_d),
        .coef_we(tb_cwe && tb_sel == 1), .coef_addr(tb_caddr), .coef_data(tb_cdata),
        .m_data(md_d), .m_chan(mc_d), .m_valid(mv_d), .m_ready(tb_mready));

    fir_tdm_decim #(.DATA_W(16), .COEF_W(16), .TAPS(8), .CHANNELS(2), .DECIM(1),
                    .OUT_W(16), .SHIFT(15)) u_s (
        .clk(clk), .rst_n(rst_n),
        .s_data(tb_data), .s_chan(tb_chan[0:0]), .s_valid(tb_valid && tb_sel == 2), .s_ready(rdy_s),
        .coef_we(tb_cwe && tb_sel == 2), .coef_addr(tb_caddr), .coef_data(tb_cdata),
        .m_data(md_s), .m_chan(mc_s), .m_valid(mv_s), .m_ready(tb_mready));

    function automatic logic f_rdy(input int i);
        case (i)
            0:       return rdy_a;
            1:       return rdy_d;
            default: return rdy_s;
        endcase
    endfunction

    function automatic logic f_mv(input int i);
        case (i)
            0:       return mv_a;
            1:       return mv_d;
            default: return mv_s;
        endcase
    endfunction

    function automatic logic signed [31:0] f_md(input int i);
        case (i)
            0:       return $signed(md_a);
            1:       return $signed(md_d);
            default: return 32'($signed(md_s));
        endcase
    endfunction

    function automatic int f_mc(input int i);
        case (i)
            0:       return int'(mc_a);
            1:       return int'(mc_d);
            default: return int'(mc_s);
        endcase
    endfunction

    task automatic chk(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input int inst, input int d, input int ch);
        int w;
        w = 0;
        while (!f_rdy(inst) && w < 200) begin
            tick();
            w++;
        end
        if (w >= 200) chk("send_ready_timeout", f_rdy(inst), 1);
        tb_sel   = inst;
        tb_data  = d[15:0];
        tb_chan  = ch[1:0];
        tb_valid = 1'b1;
        tick();
        tb_valid = 1'b0;
    endtask

    task automatic recv(input int inst, input int exp_d, input int exp_c, input string tag, output int lat);
        lat = 0;
        while (!f_mv(inst) && lat < 100) begin
            tick();
            lat++;
        end
        chk({tag, "_valid"}, f_mv(inst), 1);
        chk({tag, "_data"}, f_md(inst), exp_d);
        chk({tag, "_chan"}, f_mc(inst), exp_c);
        if (tb_mready) tick();
    endtask

    task automatic wr_coef(input int inst, input int addr, input int data);
        tb_sel   = inst;
        tb_caddr = addr[2:0];
        tb_cdata = data[15:0];
        tb_cwe   = 1'b1;
        tick();
        tb_cwe   = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        int extra;
        rst_n = 1'b1; tb_data = '0; tb_chan = '0; tb_valid = 1'b0; tb_sel = 0;
        tb_cwe = 1'b0; tb_caddr = '0; tb_cdata = '0; tb_mready = 1'b1;
        tick(); tick(); tick();

        // Reset state
        chk("rst_ready", f_rdy(0), 0);
        chk("rst_mvalid", f_mv(0), 0);
        chk("rst_mdata", f_md(0), 0);
        chk("rst_mchan", f_mc(0), 0);
        rst_n = 1'b0;
        #1;
        chk("rel_ready", f_rdy(0), 1);
        tick();

        for (int k = 0; k < 8; k++) begin
            wr_coef(0, k, k + 1);
            wr_coef(1, k, 1);
            wr_coef(2, k, 32767);
        end

        // Impulse response
        for (int i = 0; i < 8; i++) begin
            send(0, (i == 0) ? 1000 : 0, 0);
            recv(0, (i + 1) * 1000, 0, "imp", lat);
            if (i == 0) chk("imp_latency", lat, 9);
        end

        // Channel isolation
        for (int i = 0; i < 8; i++) begin
            send(0, (i == 0) ? 1000 : 0, 0);
            recv(0, (i + 1) * 1000, 0, "iso_ch0", lat);
            send(0, 100, 1);
            recv(0, 100 * (i + 1) * (i + 2) / 2, 1, "iso_ch1", lat);
        end

        // Backpressure: hold the 3600 result while a second computation stalls behind it
        send(0, 100, 1);
        tb_mready = 1'b0;
        recv(0, 3600, 1, "bp_first", lat);
        send(0, 500, 0);
        for (int i = 0; i < 50; i++) begin
            tick();
            chk("bp_hold", {f_rdy(0), f_mv(0), mc_a, md_a}, {1'b0, 1'b1, 1'b1, 32'd3600});
        end
        tb_mready = 1'b1;
        tick();
        chk("bp_reload", {f_mv(0), mc_a, md_a}, {1'b1, 1'b0, 32'd500});
        tick();
        chk("bp_drain", f_mv(0), 0);

        // Decimation by 4, with out-of-range channel samples mixed in
        for (int i = 1; i <= 16; i++) begin
            send(1, 10, 0);
            if (i % 4 == 0) recv(1, (i == 4) ? 40 : 80, 0, "decim", lat);
            else chk("decim_skip", {f_rdy(1), f_mv(1)}, 2'b10);
            if (i == 2 || i == 9) begin
                send(1, 30000, 3);
                chk("chan_oob", {f_rdy(1), f_mv(1)}, 2'b10);
            end
        end
        extra = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (f_mv(1)) extra++;
        end
        chk("decim_extra", extra, 0);

        // Saturation, floor shift and clamp on OUT_W=16, SHIFT=15
        for (int i = 0; i < 8; i++) begin
            send(2, 32767, 0);
            recv(2, (i == 0) ? 32766 : 32767, 0, "sat_pos", lat);
        end
        for (int j = 1; j <= 8; j++) begin
            send(2, -32768, 0);
            recv(2, (j <= 3) ? 32767 : ((j == 4) ? -4 : -32768), 0, "sat_neg", lat);
        end
        for (int k = 0; k < 8; k++) wr_coef(2, k, (k == 0) ? 16384 : 0);
        send(2, 16384, 0);
        recv(2, 8192, 0, "shift15", lat);

        // Reset mid-MAC aborts the computation and clears history and coefficients
        send(0, 1000, 0);
        tick(); tick();
        rst_n = 1'b1;
        #1;
        chk("midrst_state", {f_rdy(0), f_mv(0)}, 2'b00);
        tick(); tick();
        rst_n = 1'b0;
        #1;
        chk("midrst_ready", f_rdy(0), 1);
        extra = 0;
        for (int i = 0; i < 15; i++) begin
            tick();
            if (f_mv(0)) extra++;
        end
        chk("midrst_noout", extra, 0);
        send(0, 1000, 1);
        recv(0, 0, 1, "nocoef", lat);
        for (int k = 0; k < 8; k++) wr_coef(0, k, k + 1);
        send(0, 1000, 0);
        tick();
        wr_coef(0, 7, 99);
        recv(0, 1000, 0, "post_rst", lat);
        for (int i = 1; i < 8; i++) begin
            send(0, 0, 0);
            recv(0, (i + 1) * 1000, 0, "post_rst", lat);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
